// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and encodings for the multi-cycle RV32I-subset
//               control FSM: state enum, ALU operation class, datapath mux
//               select encodings and the opcodes the core understands.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

  // Controller states; FETCH must be the reset state
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  // Class of ALU operation requested by the FSM
  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } alu_op_t;

  // ALU control encodings
  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_AND = 3'b010;
  localparam logic [2:0] C_ALU_OR  = 3'b011;
  localparam logic [2:0] C_ALU_SLT = 3'b101;

  // Result mux
  localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
  localparam logic [1:0] C_RES_DATA      = 2'b01;
  localparam logic [1:0] C_RES_ALURESULT = 2'b10;

  // ALU source A mux
  localparam logic [1:0] C_SRCA_PC    = 2'b00;
  localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
  localparam logic [1:0] C_SRCA_RD1   = 2'b10;

  // ALU source B mux
  localparam logic [1:0] C_SRCB_RD2  = 2'b00;
  localparam logic [1:0] C_SRCB_IMM  = 2'b01;
  localparam logic [1:0] C_SRCB_FOUR = 2'b10;

  // Immediate format select
  localparam logic [1:0] C_IMM_I = 2'b00;
  localparam logic [1:0] C_IMM_S = 2'b01;
  localparam logic [1:0] C_IMM_B = 2'b10;
  localparam logic [1:0] C_IMM_J = 2'b11;

  // Supported opcodes
  localparam logic [6:0] C_OP_LW    = 7'b0000011;
  localparam logic [6:0] C_OP_SW    = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE = 7'b0110011;
  localparam logic [6:0] C_OP_ITYPE = 7'b0010011;
  localparam logic [6:0] C_OP_JAL   = 7'b1101111;
  localparam logic [6:0] C_OP_BEQ   = 7'b1100011;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational mapping from ALU operation class and
//               instruction fields to the ALU control code.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
  import mc_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Subtract only for R-type funct7[5]=1; I-type (op5=0) always adds
  always_comb begin
    alu_control = C_ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = C_ALU_ADD;
      ALUOP_SUB: alu_control = C_ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? C_ALU_SUB : C_ALU_ADD;
          3'b010:  alu_control = C_ALU_SLT;
          3'b110:  alu_control = C_ALU_OR;
          3'b111:  alu_control = C_ALU_AND;
          default: alu_control = C_ALU_ADD;
        endcase
      end
      default: alu_control = C_ALU_ADD;
    endcase
  end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Control FSM for the multi-cycle RV32I-subset core. Sequences
//               memory, IR, ALU, register file and PC over 3-5 cycles per
//               instruction, stalling memory states on mem_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       retire,
  output logic       illegal
);

  state_t     r_state;
  logic       r_illegal;

  logic       w_adv;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_imm_src;
  logic       w_reg_write;
  logic       w_retire;
  alu_op_t    w_alu_op;
  logic [2:0] w_alu_control;

  // Memory-facing states only advance once the access completes
  always_comb begin
    w_adv = 1'b1;
    if ((r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE))
      w_adv = mem_ready;
  end

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else if (w_adv) begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            C_OP_LW, C_OP_SW: r_state <= S_MEMADR;
            C_OP_RTYPE:       r_state <= S_EXECR;
            C_OP_ITYPE:       r_state <= S_EXECI;
            C_OP_JAL:         r_state <= S_JAL;
            C_OP_BEQ:         r_state <= S_BEQ;
            default: begin
              r_state   <= S_FETCH;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: r_state <= S_FETCH;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
        S_BEQ:      r_state <= S_FETCH;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; the only mem_ready-qualified outputs are the
  // fetch-side loads and the store retire pulse
  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_result_src = C_RES_ALUOUT;
    w_alu_src_a  = C_SRCA_PC;
    w_alu_src_b  = C_SRCB_RD2;
    w_reg_write  = 1'b0;
    w_retire     = 1'b0;
    w_alu_op     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = C_SRCB_FOUR;
        w_result_src = C_RES_ALURESULT;
        w_ir_write   = mem_ready;
        w_pc_update  = mem_ready;
      end
      S_DECODE: begin
        w_alu_src_a = C_SRCA_OLDPC;
        w_alu_src_b = C_SRCB_IMM;
      end
      S_MEMADR: begin
        w_alu_src_a = C_SRCA_RD1;
        w_alu_src_b = C_SRCB_IMM;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = C_RES_DATA;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = mem_ready;
      end
      S_EXECR: begin
        w_alu_src_a = C_SRCA_RD1;
        w_alu_op    = ALUOP_FUNC;
      end
      S_EXECI: begin
        w_alu_src_a = C_SRCA_RD1;
        w_alu_src_b = C_SRCB_IMM;
        w_alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_JAL: begin
        w_alu_src_a = C_SRCA_OLDPC;
        w_alu_src_b = C_SRCB_FOUR;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a = C_SRCA_RD1;
        w_alu_op    = ALUOP_SUB;
        w_branch    = 1'b1;
        w_retire    = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      C_OP_LW, C_OP_ITYPE: w_imm_src = C_IMM_I;
      C_OP_SW:             w_imm_src = C_IMM_S;
      C_OP_BEQ:            w_imm_src = C_IMM_B;
      C_OP_JAL:            w_imm_src = C_IMM_J;
      default:             w_imm_src = C_IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (w_alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (w_alu_control)
  );

  // Reset masks every output so no strobe can fire while aborting
  always_comb begin
    pc_write    = ~reset & ((w_pc_update & w_adv) | (w_branch & zero));
    adr_src     = ~reset & w_adr_src;
    mem_write   = ~reset & w_mem_write;
    ir_write    = ~reset & w_ir_write;
    result_src  = reset ? 2'b00 : w_result_src;
    alu_src_a   = reset ? 2'b00 : w_alu_src_a;
    alu_src_b   = reset ? 2'b00 : w_alu_src_b;
    alu_control = reset ? 3'b000 : w_alu_control;
    imm_src     = reset ? 2'b00 : w_imm_src;
    reg_write   = ~reset & w_reg_write;
    retire      = ~reset & w_retire;
    illegal     = ~reset & r_illegal;
  end

endmodule : multicycle_controller
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed self-checking bench for multicycle_controller.
//               Each step compares the full output bundle against a
//               hand-derived vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .reg_write   (reg_write),
    .retire      (retire),
    .illegal     (illegal)
  );

  // Output bundle: pcw adr mw irw rs[2] sa[2] sb[2] ac[3] imm[2] rw ret ill
  logic [17:0] w_obs;
  assign w_obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, alu_control, imm_src, reg_write, retire, illegal};

  function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] ac, input logic [1:0] imm,
                                     input logic rw, input logic ret, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw, ret, ill};
  endfunction

  // Check mid-cycle on the falling edge, then move to just after the next rising edge
  task automatic cyc(input string tag, input logic [17:0] exp);
    @(negedge clk);
    checks++;
    assert (w_obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, w_obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] e_zero;
    e_zero = '0;

    reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;

    // Reset held two cycles: every output low
    cyc("rst0", e_zero);
    cyc("rst1", e_zero);
    reset = 1'b0;

    // lw: five cycles, writeback only in the last
    cyc("lw_fetch",   mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("lw_decode",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("lw_memadr",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("lw_memread", mk(1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("lw_memwb",   mk(1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,3'd0,2'd0,1'b1,1'b1,1'b0));

    // R-type sub, with one fetch stall first
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; mem_ready = 1'b0;
    cyc("sub_fetch_stall", mk(1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd2,3'd0,2'd0,1'b0,1'b0,1'b0));
    mem_ready = 1'b1;
    cyc("sub_fetch",  mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("sub_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("sub_execr",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,3'd1,2'd0,1'b0,1'b0,1'b0));
    cyc("sub_aluwb",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,2'd0,1'b1,1'b1,1'b0));

    // R-type slt
    funct3 = 3'b010; funct7b5 = 1'b0;
    cyc("slt_fetch",  mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("slt_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("slt_execr",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,3'd5,2'd0,1'b0,1'b0,1'b0));
    cyc("slt_aluwb",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,2'd0,1'b1,1'b1,1'b0));

    // addi with funct7b5=1 must still add (op[5]=0)
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    cyc("addi_fetch",  mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("addi_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("addi_execi",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("addi_aluwb",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,2'd0,1'b1,1'b1,1'b0));

    // andi and ori: only EXECI differs
    funct3 = 3'b111; funct7b5 = 1'b0;
    cyc("andi_fetch",  mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("andi_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("andi_execi",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd2,2'd0,1'b0,1'b0,1'b0));
    cyc("andi_aluwb",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,2'd0,1'b1,1'b1,1'b0));
    funct3 = 3'b110;
    cyc("ori_fetch",  mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("ori_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("ori_execi",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd3,2'd0,1'b0,1'b0,1'b0));
    cyc("ori_aluwb",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,2'd0,1'b1,1'b1,1'b0));

    // beq taken; zero=1 in DECODE must not write the PC
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    cyc("beqt_fetch",  mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd2,1'b0,1'b0,1'b0));
    cyc("beqt_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd2,1'b0,1'b0,1'b0));
    cyc("beqt_beq",    mk(1'b1,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,3'd1,2'd2,1'b0,1'b1,1'b0));

    // beq not taken
    zero = 1'b0;
    cyc("beqn_fetch",  mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd2,1'b0,1'b0,1'b0));
    cyc("beqn_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd2,1'b0,1'b0,1'b0));
    cyc("beqn_beq",    mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,3'd1,2'd2,1'b0,1'b1,1'b0));

    // sw with three wait cycles in MEMWRITE: seven cycles total
    op = 7'b0100011;
    cyc("sw_fetch",  mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd1,1'b0,1'b0,1'b0));
    cyc("sw_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd1,1'b0,1'b0,1'b0));
    cyc("sw_memadr", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd0,2'd1,1'b0,1'b0,1'b0));
    mem_ready = 1'b0;
    cyc("sw_wait0",  mk(1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,3'd0,2'd1,1'b0,1'b0,1'b0));
    cyc("sw_wait1",  mk(1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,3'd0,2'd1,1'b0,1'b0,1'b0));
    cyc("sw_wait2",  mk(1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,3'd0,2'd1,1'b0,1'b0,1'b0));
    mem_ready = 1'b1;
    cyc("sw_ready",  mk(1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,3'd0,2'd1,1'b0,1'b1,1'b0));

    // Illegal opcode: two cycles, then sticky flag
    op = 7'b1111111;
    cyc("ill_fetch",  mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("ill_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd0,1'b0,1'b0,1'b0));

    // jal after the illegal opcode
    op = 7'b1101111;
    cyc("jal_fetch",  mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd3,1'b0,1'b0,1'b1));
    cyc("jal_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd3,1'b0,1'b0,1'b1));
    cyc("jal_jal",    mk(1'b1,1'b0,1'b0,1'b0,2'd0,2'd1,2'd2,3'd0,2'd3,1'b0,1'b0,1'b1));
    cyc("jal_aluwb",  mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,2'd3,1'b1,1'b1,1'b1));

    // lw aborted by reset in MEMREAD; restart in FETCH with illegal cleared
    op = 7'b0000011;
    cyc("lwa_fetch",  mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd0,1'b0,1'b0,1'b1));
    cyc("lwa_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd0,1'b0,1'b0,1'b1));
    cyc("lwa_memadr", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd0,2'd0,1'b0,1'b0,1'b1));
    reset = 1'b1;
    cyc("lwa_rst",    e_zero);
    reset = 1'b0;
    cyc("lwa_refetch", mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,2'd0,1'b0,1'b0,1'b0));
    cyc("lwa_redecode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,2'd0,1'b0,1'b0,1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multicycle_controller
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multi-cycle RV32I-subset core: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal. It sequences the shared memory, the instruction register, the ALU, the register file and the PC across 3–5 cycles per instruction. Memory accesses stall on a ready handshake. It sits beside the datapath in the core top, and its ports connect one-to-one to the datapath mux selects and enables.

## Interface
Parameters: none.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; sampled on rising clk
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle; tie to 1 for zero-wait memory
- pc_write  out  1  PC enable = (pc_update & adv) | (branch & zero)
- adr_src  out  1  0 = PC, 1 = Result
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction register and OldPC load
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1
- alu_src_b  out  2  00 = RD2, 01 = Imm, 10 = constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- reg_write  out  1  register file write enable
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  sticky; set on an unsupported opcode in DECODE, cleared only by reset

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ.
- Moore outputs are decoded from the state. Signals not listed for a state are 0.
- `adv` = mem_ready in FETCH, MEMREAD and MEMWRITE; 1 in every other state. The state advances only when adv = 1; otherwise it holds and outputs repeat.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op add, result_src=10. ir_write and pc_update are asserted only when mem_ready=1. Next state DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op add (branch target). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - anything else → FETCH, with illegal set and no retire
- MEMADR: alu_src_a=10, alu_src_b=01, add. Next state MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Next state MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1. Next state FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 while waiting. retire=1 on the cycle mem_ready=1. Next state FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op func. EXECI: alu_src_a=10, alu_src_b=01, alu_op func. Both go to ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1. Next state FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_update=1. Next state ALUWB.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, branch=1, retire=1. Next state FETCH.
- ALU decode:
  - alu_op add → 000; sub → 001.
  - alu_op func, by funct3:
    - 000 → sub (001) iff op[5]&funct7b5, else add (000)
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - other → 000
- imm_src is combinational from op in every state: lw/I-type → 00, sw → 01, beq → 10, jal → 11, other → 00.

## Timing
- Reset: state ← FETCH and illegal ← 0. While reset=1, every output is forced to 0, ignoring state. The first fetch runs on the first cycle after reset deasserts.
- Reset asserted mid-instruction aborts it on the next edge. No write strobe is asserted during reset.
- Latency with mem_ready=1: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles; illegal opcode 2 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- pc_write is combinational from state, zero and mem_ready. zero is sampled in BEQ only.

## Structure
- Package `mc_pkg` holds:
  - state enum
  - alu_op encoding (add, sub, func)
  - alu_control, result_src, alu_src_a, alu_src_b and imm_src encodings
  - opcode constants
- Sub-module `alu_decoder` (alu_op, funct3, op5, funct7b5 → alu_control) is purely combinational.
- The FSM, output decode and imm_src decode live in multicycle_controller.

## Test plan
- Reset held for 2 cycles, then released with op=0000011 and mem_ready=1 → all outputs 0 during reset; then the sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 and retire=1 appear only in cycle 5.
- R-type with op=0110011, funct3=000, funct7b5=1 → alu_control=001 in EXECR; ALUWB reg_write=1. With funct3=010, alu_control=101.
- beq with zero=1 in BEQ → pc_write=1 in cycle 3. With zero=0 → pc_write=0 in cycle 3. retire=1 in both cases.
- sw with mem_ready held 0 for 3 cycles in MEMWRITE → mem_write=1 for 4 cycles; retire is a single pulse on the ready cycle; total latency 7 cycles.
- op=1111111 → illegal=1 from the cycle after DECODE; state returns to FETCH; no reg_write or mem_write. A following jal retires after 4 cycles with pc_write=1 in FETCH and JAL.
- reset asserted in MEMREAD → next cycle is FETCH with all outputs 0 during reset, and no MEMWB write occurs.
